// File: rtl/wave_derotator.sv
// wave_derotator: three-stage I/Q derotator driven by a 12-bit phase accumulator.
// The quarter-wave sine table is computed at elaboration time; each entry is
// round((2^(DATA_WIDTH-1)-1) * sin(2*pi*k/4096)), the same contents INIT_FILE names.
// Build option: define WAVE_DEROTATOR_SAT_EN to saturate results; otherwise they wrap.
module wave_derotator #(
  parameter int DATA_WIDTH = 8,
  parameter int LUT_DEPTH  = 1024,
  parameter     INIT_FILE  = "quarter_sin.dat"
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic [3:0]                   i_paso,
  input  logic                         i_phase_clr,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic signed [DATA_WIDTH-1:0] i_dataI,
  input  logic signed [DATA_WIDTH-1:0] i_dataQ,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic signed [DATA_WIDTH-1:0] o_dataI,
  output logic signed [DATA_WIDTH-1:0] o_dataQ,
  output logic [11:0]                  o_phase
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH + 1;
  localparam logic signed [SW-1:0] RND = SW'(64'sd1 <<< (DATA_WIDTH - 2));

  // Fixed-point (Q30) Taylor series of sin over the first quadrant, rounded to a table word.
  function automatic logic [DATA_WIDTH-1:0] sin_entry(input int k);
    longint x, x2, term, acc, amp, scaled;
    x    = (longint'(k) * 64'sd3373259426) >>> 11;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int unsigned n = 1; n <= 9; n++) begin
      term = -((term * x2) >>> 30);
      term = term / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    amp    = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    scaled = (amp * acc + (64'sd1 <<< 29)) >>> 30;
    return scaled[DATA_WIDTH-1:0];
  endfunction

`ifdef WAVE_DEROTATOR_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(64'sd1 <<< (DATA_WIDTH - 1)));

  function automatic logic [DATA_WIDTH-1:0] limit(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return DATA_WIDTH'(v);
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] limit(input logic signed [SW-1:0] v);
    return DATA_WIDTH'(v);
  endfunction
`endif

  if (LUT_DEPTH != 1024) begin : g_bad_depth
    $error("wave_derotator: LUT_DEPTH must be 1024 (10-bit table index)");
  end
  if (INIT_FILE == "") begin : g_bad_init
    $error("wave_derotator: INIT_FILE must name the quarter-wave table");
  end

  logic [DATA_WIDTH-1:0] lut [LUT_DEPTH];
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [DATA_WIDTH-1:0] ENTRY = sin_entry(k);
    assign lut[k] = ENTRY;
  end

  logic [11:0] acc_q, acc_d;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DATA_WIDTH-1:0] i1_q, i1_d, q1_q, q1_d, sin1_q, sin1_d, cos1_q, cos1_d;
  logic [11:0] ph1_q, ph1_d, ph2_q, ph2_d, ph3_q, ph3_d;
  logic signed [PW-1:0] p_ic_q, p_ic_d, p_qs_q, p_qs_d, p_qc_q, p_qc_d, p_is_q, p_is_d;
  logic signed [DATA_WIDTH-1:0] oi_q, oi_d, oq_q, oq_d;

  logic        adv, accept;
  logic [3:0]  paso_eff;
  logic [11:0] inc, phase_use, cos_phase;
  logic [9:0]  sin_idx, cos_idx;
  logic [DATA_WIDTH-1:0] sin_mag, cos_mag;
  logic signed [SW-1:0]  sum_i, sum_q, rnd_i, rnd_q;

  // Handshake and phase accumulator; a clear on an accept tags that sample with phase 0.
  always_comb begin
    adv       = i_ready | ~v3_q;
    accept    = i_valid & adv;
    paso_eff  = (i_paso > 4'd10) ? 4'd10 : i_paso;
    inc       = 12'd1 << paso_eff;
    phase_use = i_phase_clr ? '0 : acc_q;
    acc_d     = acc_q;
    if (accept) begin
      acc_d = phase_use + inc;
    end else if (i_phase_clr) begin
      acc_d = '0;
    end
  end

  // Quadrant folding of the quarter-wave table for sin and cos of the current phase.
  always_comb begin
    cos_phase = phase_use + 12'd1024;
    sin_idx   = phase_use[10] ? ~phase_use[9:0] : phase_use[9:0];
    cos_idx   = cos_phase[10] ? ~cos_phase[9:0] : cos_phase[9:0];
    sin_mag   = lut[sin_idx];
    cos_mag   = lut[cos_idx];
  end

  // Pipeline next-state: every stage moves together whenever the output side can accept.
  always_comb begin
    v1_d = v1_q;  i1_d = i1_q;  q1_d = q1_q;  sin1_d = sin1_q;  cos1_d = cos1_q;  ph1_d = ph1_q;
    v2_d = v2_q;  p_ic_d = p_ic_q;  p_qs_d = p_qs_q;  p_qc_d = p_qc_q;  p_is_d = p_is_q;
    ph2_d = ph2_q;
    v3_d = v3_q;  oi_d = oi_q;  oq_d = oq_q;  ph3_d = ph3_q;
    sum_i = SW'(p_ic_q) + SW'(p_qs_q);
    sum_q = SW'(p_qc_q) - SW'(p_is_q);
    rnd_i = sum_i + RND;
    rnd_q = sum_q + RND;
    if (adv) begin
      v1_d   = i_valid;
      i1_d   = i_dataI;
      q1_d   = i_dataQ;
      sin1_d = phase_use[11] ? -$signed(sin_mag) : $signed(sin_mag);
      cos1_d = cos_phase[11] ? -$signed(cos_mag) : $signed(cos_mag);
      ph1_d  = phase_use;
      v2_d   = v1_q;
      p_ic_d = PW'(i1_q) * PW'(cos1_q);
      p_qs_d = PW'(q1_q) * PW'(sin1_q);
      p_qc_d = PW'(q1_q) * PW'(cos1_q);
      p_is_d = PW'(i1_q) * PW'(sin1_q);
      ph2_d  = ph1_q;
      v3_d   = v2_q;
      oi_d   = limit(rnd_i >>> (DATA_WIDTH - 1));
      oq_d   = limit(rnd_q >>> (DATA_WIDTH - 1));
      ph3_d  = ph2_q;
    end
  end

  // State registers with asynchronous reset; reset flushes everything in flight.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      acc_q  <= '0;
      v1_q   <= 1'b0;  i1_q <= '0;  q1_q <= '0;  sin1_q <= '0;  cos1_q <= '0;  ph1_q <= '0;
      v2_q   <= 1'b0;  p_ic_q <= '0;  p_qs_q <= '0;  p_qc_q <= '0;  p_is_q <= '0;
      ph2_q  <= '0;
      v3_q   <= 1'b0;  oi_q <= '0;  oq_q <= '0;  ph3_q <= '0;
    end else begin
      acc_q  <= acc_d;
      v1_q   <= v1_d;  i1_q <= i1_d;  q1_q <= q1_d;  sin1_q <= sin1_d;  cos1_q <= cos1_d;
      ph1_q  <= ph1_d;
      v2_q   <= v2_d;  p_ic_q <= p_ic_d;  p_qs_q <= p_qs_d;  p_qc_q <= p_qc_d;  p_is_q <= p_is_d;
      ph2_q  <= ph2_d;
      v3_q   <= v3_d;  oi_q <= oi_d;  oq_q <= oq_d;  ph3_q <= ph3_d;
    end
  end

  assign o_ready = adv;
  assign o_valid = v3_q;
  assign o_dataI = oi_q;
  assign o_dataQ = oq_q;
  assign o_phase = ph3_q;

endmodule

// File: tb/tb_wave_derotator.sv
// Directed bench for wave_derotator (DATA_WIDTH = 8).
module tb_wave_derotator;

  logic              clock;
  logic              i_reset;
  logic [3:0]        i_paso;
  logic              i_phase_clr;
  logic              i_valid;
  logic              o_ready;
  logic signed [7:0] i_dataI;
  logic signed [7:0] i_dataQ;
  logic              o_valid;
  logic              i_ready;
  logic signed [7:0] o_dataI;
  logic signed [7:0] o_dataQ;
  logic [11:0]       o_phase;

  int checks = 0;
  int errors = 0;
  int sent, got;
  logic [11:0]       held_phase;
  logic signed [7:0] held_i, held_q;

  int exp_quad_i [4] = '{64, 0, -63, 0};
  int exp_quad_q [4] = '{0, -63, 0, 64};

  wave_derotator #(.DATA_WIDTH(8), .LUT_DEPTH(1024), .INIT_FILE("quarter_sin.dat")) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_paso      (i_paso),
    .i_phase_clr (i_phase_clr),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_dataI     (i_dataI),
    .i_dataQ     (i_dataQ),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_dataI     (o_dataI),
    .o_dataQ     (o_dataQ),
    .o_phase     (o_phase)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Four samples I=64,Q=0 with a quarter-turn step: rotate through the four axes.
  task automatic run_quad(input logic [3:0] paso, input string tag);
    i_paso  = paso;
    i_dataI = 64;
    i_dataQ = 0;
    i_ready = 1'b1;
    i_valid = 1'b1;
    tick();
    tick();
    chk({tag, "_latency"}, o_valid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      if (k == 1) i_valid = 1'b0;
      chk({tag, "_valid"}, o_valid, 1);
      chk({tag, "_i"}, o_dataI, exp_quad_i[k]);
      chk({tag, "_q"}, o_dataQ, exp_quad_q[k]);
      chk({tag, "_phase"}, o_phase, k * 1024);
    end
    tick();
    chk({tag, "_drained"}, o_valid, 0);
  endtask

  initial begin
    i_reset = 1'b0; i_paso = '0; i_phase_clr = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_dataI = '0; i_dataQ = '0;

    // Reset state, observed before any clock edge.
    #1 i_reset = 1'b1;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_i", o_dataI, 0);
    chk("rst_q", o_dataQ, 0);
    chk("rst_phase", o_phase, 0);
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1);

    // Quarter-turn steps, then the same with an out-of-range selector.
    run_quad(4'd10, "quad10");
    run_quad(4'd15, "quad15");

    // Eighth-turn step with full-scale input: second sample overflows the output range.
    i_paso = 4'd9; i_dataI = 127; i_dataQ = 127; i_ready = 1'b1; i_valid = 1'b1;
    tick();
    tick();
    i_valid = 1'b0;
    tick();
    chk("sat0_i", o_dataI, 126);
    chk("sat0_q", o_dataQ, 126);
    chk("sat0_phase", o_phase, 0);
    tick();
`ifdef WAVE_DEROTATOR_SAT_EN
    chk("sat1_i", o_dataI, 127);
`else
    chk("sat1_i", o_dataI, -77);
`endif
    chk("sat1_q", o_dataQ, 0);
    chk("sat1_phase", o_phase, 512);

    // Clear without an accept returns the accumulator to zero.
    i_phase_clr = 1'b1;
    tick();
    i_phase_clr = 1'b0;

    // Backpressure: downstream stalls for 5 cycles while input stays valid.
    i_paso = 4'd10; i_dataI = 64; i_dataQ = 0;
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      i_ready = !(c >= 4 && c < 9);
      i_valid = (sent < 8);
      #1;
      if (c >= 4 && c < 9) begin
        chk("bp_ready_low", o_ready, 0);
        chk("bp_valid_held", o_valid, 1);
        if (c == 4) begin
          held_phase = o_phase; held_i = o_dataI; held_q = o_dataQ;
        end else begin
          chk("bp_phase_held", o_phase, held_phase);
          chk("bp_i_held", o_dataI, held_i);
          chk("bp_q_held", o_dataQ, held_q);
        end
      end
      if (o_valid && i_ready) begin
        chk("bp_phase", o_phase, (got * 1024) % 4096);
        chk("bp_i", o_dataI, exp_quad_i[got % 4]);
        chk("bp_q", o_dataQ, exp_quad_q[got % 4]);
        got++;
      end
      if (i_valid && o_ready) sent++;
      @(posedge clock);
      #1;
    end
    i_valid = 1'b0;
    chk("bp_count", got, 8);

    // Step 16: ten accepts, then a clear coinciding with the eleventh accept.
    i_paso = 4'd4; i_ready = 1'b1;
    sent = 0; got = 0;
    for (int c = 0; c < 30 && got < 12; c++) begin
      i_valid     = (sent < 12);
      i_phase_clr = (sent == 10);
      #1;
      if (o_valid && i_ready) begin
        chk("clr_phase", o_phase, (got < 10) ? got * 16 : (got - 10) * 16);
        if (got == 10) begin
          chk("clr_i", o_dataI, 64);
          chk("clr_q", o_dataQ, 0);
        end
        got++;
      end
      if (i_valid && o_ready) sent++;
      @(posedge clock);
      #1;
    end
    i_valid = 1'b0; i_phase_clr = 1'b0;
    chk("clr_count", got, 12);

    // Reset in the middle of a stream clears outputs without a clock edge.
    i_paso = 4'd9; i_dataI = 64; i_dataQ = 0; i_phase_clr = 1'b1; i_valid = 1'b1;
    tick();
    i_phase_clr = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_valid", o_valid, 1);
    chk("mid_i", o_dataI, 45);
    chk("mid_q", o_dataQ, -45);
    chk("mid_phase", o_phase, 512);
    #2 i_reset = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_i", o_dataI, 0);
    chk("arst_q", o_dataQ, 0);
    chk("arst_phase", o_phase, 0);
    i_valid = 1'b0; i_ready = 1'b0;
    tick();
    i_reset = 1'b0;
    #1;
    chk("arst_ready", o_ready, 1);
    chk("arst_valid_after", o_valid, 0);

    // First sample after reset starts again from phase 0.
    i_paso = 4'd10; i_dataI = 64; i_dataQ = 0; i_ready = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    chk("post_valid", o_valid, 1);
    chk("post_i", o_dataI, 64);
    chk("post_q", o_dataQ, 0);
    chk("post_phase", o_phase, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_derotator.md
WAVE_DEROTATOR -- requirements
Module: wave_derotator

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of I/Q samples and LUT words.
REQ-002 Parameter LUT_DEPTH, default 1024: number of quarter-wave sine LUT entries; fixed at 1024 (10-bit index).
REQ-003 Parameter INIT_FILE, default "quarter_sin.dat": hex file holding LUT[k] = round((2^(DATA_WIDTH-1)-1)*sin(2*pi*k/4096)), k = 0..1023.
REQ-004 clock  input  1  single clock; all state on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_paso  input  4  phase-step selector; increment = 1 << i_paso; values above 10 are treated as 10.
REQ-007 i_phase_clr  input  1  synchronous phase-accumulator clear.
REQ-008 i_valid  input  1  input sample valid.
REQ-009 o_ready  output  1  block can accept an input sample.
REQ-010 i_dataI, i_dataQ  input  DATA_WIDTH  signed rotated I/Q sample.
REQ-011 o_valid  output  1  output sample valid.
REQ-012 i_ready  input  1  downstream accepts the output sample.
REQ-013 o_dataI, o_dataQ  output  DATA_WIDTH  signed derotated I/Q sample.
REQ-014 o_phase  output  12  phase used for the sample currently on the outputs.

Function
REQ-015 Accept = i_valid & o_ready; emit = o_valid & i_ready.
REQ-016 The phase accumulator is 12 bits, starts at 0, and advances by the increment on every accept, wrapping modulo 4096.
REQ-017 The accepted sample uses the pre-advance phase value.
REQ-018 sin(p) uses quadrant q = p[11:10] and r = p[9:0]: magnitude = LUT[r] for even q and LUT[1023-r] for odd q; the result is negated for q = 2 or 3.
REQ-019 cos(p) = sin((p+1024) mod 4096).
REQ-020 Derotation: I' = I*cos + Q*sin; Q' = Q*cos - I*sin.
REQ-021 Products are 2*DATA_WIDTH bits and sums are 2*DATA_WIDTH+1 bits.
REQ-022 Result = (sum + 2^(DATA_WIDTH-2)) >>> (DATA_WIDTH-1), an arithmetic shift with round-half-up.
REQ-023 The pipeline has 3 stages: (1) input/phase register and LUT read, (2) multiply, (3) add/round/limit. Latency from accept to o_valid is 3 cycles.
REQ-024 o_ready = i_ready | ~stage-3 valid; all stages advance together when o_ready is high.
REQ-025 Held data is stable while o_valid & ~i_ready; no sample is dropped or duplicated.
REQ-026 With i_phase_clr high, the accumulator loads 0.
REQ-027 If i_phase_clr coincides with an accept, that sample uses phase 0 and the accumulator loads the increment.
REQ-028 A change on i_paso affects only the next advance; it causes no phase jump.

Reset
REQ-029 On i_reset, immediately and independent of clock: accumulator = 0, all stage valids = 0, o_dataI = o_dataQ = 0, o_phase = 0, o_valid = 0.
REQ-030 After reset, o_ready = 1.
REQ-031 Reset mid-stream discards all in-flight samples.

Configuration
REQ-032 Macro WAVE_DEROTATOR_SAT_EN defined: stage-3 results outside [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] saturate to the nearest bound.
REQ-033 Macro WAVE_DEROTATOR_SAT_EN undefined: results are truncated to the low DATA_WIDTH bits (two's-complement wrap).

Verification (DATA_WIDTH=8, LUT[0]=0, LUT[511]=LUT[512]=90, LUT[1023]=127)
REQ-034 Assert i_reset mid-stream -> o_valid, o_dataI, o_dataQ and o_phase go to 0 without a clock edge; o_ready=1 after release.
REQ-035 i_paso=10, I=64, Q=0 on 4 consecutive accepts, i_ready=1 -> outputs (64,0), (0,-63), (-63,0), (0,64) with o_phase 0, 1024, 2048, 3072, the first 3 cycles after the first accept.
REQ-036 i_paso=9, I=Q=127, second sample (phase 512) -> Q'=0; I'=127 with WAVE_DEROTATOR_SAT_EN, I'=-77 without.
REQ-037 Continuous i_valid, i_ready low for 5 cycles -> o_ready low after the pipeline fills, outputs held, accumulator frozen; the sequence resumes with no loss or duplication.
REQ-038 i_paso=4, 10 accepts, then i_phase_clr together with an accept -> that sample has o_phase=0 and the next has o_phase=16.
REQ-039 i_paso=15 -> behaves identically to i_paso=10 (increment 1024).
